pattern_source: RTL



---
 rtl/pattern_source.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pattern_source.sv
// pattern_source: drives fixed 5x5 test images into a free-running classifier,
// waits for the first full classification window, captures the result and
// reports it against the expected class, with saturating pass/fail counters
// and a watchdog for a missing classifier ready pulse.
//
// Build option: define PATTERN_SOURCE_NOISE_EN to flip one pseudo-random
// pixel per accepted request, selected by a 5-bit LFSR (x^5 + x^3 + 1).
module pattern_source #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [1:0]       req_class,
    output logic             req_ready,
    output logic [WIDTH-1:0] img,
    output logic             img_en,
    input  logic [1:0]       cls_in,
    input  logic             cls_ready,
    output logic             rsp_valid,
    output logic             rsp_match,
    output logic [1:0]       rsp_class,
    output logic             rsp_timeout,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    // Watchdog must be able to hold WIDTH+2.
    localparam int unsigned WdW = $clog2(WIDTH + 3);
    // Last count value that still tolerates a missing cls_ready; one more
    // silent cycle means the classifier has stalled.
    localparam logic [WdW-1:0] WdLast = WdW'(WIDTH + 1);
    localparam logic [WdW-1:0] WdOne  = WdW'(1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    localparam logic [WIDTH-1:0] ImgCross  = WIDTH'(25'h1151151);
    localparam logic [WIDTH-1:0] ImgCircle = WIDTH'(25'h0E8C62E);

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StHold,
        StReport
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] img_q, img_d;
    logic             img_en_q, img_en_d;
    logic [1:0]       exp_q, exp_d;
    logic [1:0]       cls_q, cls_d;
    logic             tmo_q, tmo_d;
    logic [WdW-1:0]   wdog_q, wdog_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;

    logic [WIDTH-1:0] pat_img;
    logic [1:0]       pat_exp;
    logic [WIDTH-1:0] load_img;
    logic             in_report;
    logic             match;

`ifdef PATTERN_SOURCE_NOISE_EN
    logic [4:0]       lfsr_q, lfsr_d;
    logic [WIDTH-1:0] noise_mask;

    // One-hot flip mask from the pre-advance LFSR value; out-of-range values flip nothing.
    always_comb begin
        noise_mask = '0;
        if (32'(lfsr_q) < WIDTH) begin
            noise_mask = WIDTH'(1) << lfsr_q;
        end
    end

    assign load_img = pat_img ^ noise_mask;

    // LFSR advances only when a request is accepted.
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == StIdle && req_valid) begin
            lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 5'b00001;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign load_img = pat_img;
`endif

    // Request code to test image and the class the classifier should report.
    always_comb begin
        pat_img = '0;
        pat_exp = 2'b00;
        unique case (req_class)
            2'b10: begin
                pat_img = ImgCross;
                pat_exp = 2'b10;
            end
            2'b01: begin
                pat_img = ImgCircle;
                pat_exp = 2'b01;
            end
            2'b11: begin
                // A blank-white image is not a shape; the classifier should say 00.
                pat_img = '1;
                pat_exp = 2'b00;
            end
            default: begin
                pat_img = '0;
                pat_exp = 2'b00;
            end
        endcase
    end

    assign in_report = (state_q == StReport);
    assign match     = !tmo_q && (cls_q == exp_q);

    // Next-state and handshake/strobe outputs.
    always_comb begin
        state_d   = state_q;
        img_d     = img_q;
        img_en_d  = img_en_q;
        exp_d     = exp_q;
        cls_d     = cls_q;
        tmo_d     = tmo_q;
        wdog_d    = wdog_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                // A cls_ready in this same cycle is deliberately not counted.
                if (req_valid) begin
                    img_d    = load_img;
                    exp_d    = pat_exp;
                    img_en_d = 1'b1;
                    wdog_d   = '0;
                    state_d  = StSync;
                end
            end

            StSync: begin
                // First pulse closes a window that started before the image
                // was stable, so its result is discarded.
                if (cls_ready) begin
                    wdog_d  = '0;
                    state_d = StHold;
                end else if (wdog_q == WdLast) begin
                    wdog_d  = wdog_q + WdOne;
                    cls_d   = 2'b00;
                    tmo_d   = 1'b1;
                    state_d = StReport;
                end else begin
                    wdog_d = wdog_q + WdOne;
                end
            end

            StHold: begin
                // This pulse ends a window seen entirely with our image.
                if (cls_ready) begin
                    wdog_d  = '0;
                    cls_d   = cls_in;
                    tmo_d   = 1'b0;
                    state_d = StReport;
                end else if (wdog_q == WdLast) begin
                    wdog_d  = wdog_q + WdOne;
                    cls_d   = 2'b00;
                    tmo_d   = 1'b1;
                    state_d = StReport;
                end else begin
                    wdog_d = wdog_q + WdOne;
                end
            end

            StReport: begin
                rsp_valid = 1'b1;
                if (match) begin
                    if (pass_q != '1) begin
                        pass_d = pass_q + CntOne;
                    end
                end else begin
                    if (fail_q != '1) begin
                        fail_d = fail_q + CntOne;
                    end
                end
                img_en_d = 1'b0;
                wdog_d   = '0;
                state_d  = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: image, expected/captured class, watchdog, counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_q    <= '0;
            img_en_q <= 1'b0;
            exp_q    <= 2'b00;
            cls_q    <= 2'b00;
            tmo_q    <= 1'b0;
            wdog_q   <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
        end else begin
            img_q    <= img_d;
            img_en_q <= img_en_d;
            exp_q    <= exp_d;
            cls_q    <= cls_d;
            tmo_q    <= tmo_d;
            wdog_q   <= wdog_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

    assign img         = img_q;
    assign img_en      = img_en_q;
    assign rsp_class   = cls_q;
    // Verdict flags are only asserted alongside the result strobe.
    assign rsp_match   = in_report && match;
    assign rsp_timeout = in_report && tmo_q;
    assign pass_cnt    = pass_q;
    assign fail_cnt    = fail_q;

endmodule
